// File: rtl/uart_frame_assembler_pkg.sv
// Shared constants and state encoding for the UART frame assembler and its
// receiver-side neighbours.
package uart_frame_assembler_pkg;

    localparam int unsigned UART_BYTE_WIDTH   = 8;
    localparam int unsigned UART_CONFIG_WIDTH = 32;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPayload = 2'd1,
        StCheck   = 2'd2,
        StHold    = 2'd3
    } frame_state_e;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte gap counter: cleared on demand, counts while enabled and flags the
// cycle on which the gap limit is reached.
module uart_byte_timeout
    import uart_frame_assembler_pkg::*;
#(
    parameter int unsigned            COUNT_WIDTH = UART_CONFIG_WIDTH,
    parameter logic [COUNT_WIDTH-1:0] LIMIT       = COUNT_WIDTH'(100)
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Expire
);

    localparam logic [COUNT_WIDTH-1:0] LAST = LIMIT - COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] count_q;

    // Clear has priority, so a byte arriving on the limit cycle never expires.
    assign o_Expire = i_Enable && !i_Clear && (count_q == LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Clear || o_Expire) begin
            count_q <= '0;
        end else if (i_Enable) begin
            count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles sync + payload + XOR checksum frames from UART byte pulses and
// presents the payload as one word over a valid/ready handshake.
module uart_frame_assembler
    import uart_frame_assembler_pkg::*;
#(
    parameter int unsigned                  UART_DATA_WIDTH   = UART_BYTE_WIDTH,
    parameter int unsigned                  CONFIG_DATA_WIDTH = UART_CONFIG_WIDTH,
    parameter int unsigned                  PAYLOAD_BYTES     = 4,
    parameter logic [UART_DATA_WIDTH-1:0]   SYNC_BYTE         = DEFAULT_SYNC_BYTE,
    parameter logic [CONFIG_DATA_WIDTH-1:0] TIMEOUT_CLKS      = 32'd100000,
    localparam int unsigned                 FRAME_WIDTH       = PAYLOAD_BYTES * UART_DATA_WIDTH
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Rx_DV,
    input  logic [UART_DATA_WIDTH-1:0] i_Rx_Byte,
    output logic                       o_Frame_Valid,
    input  logic                       i_Frame_Ready,
    output logic [FRAME_WIDTH-1:0]     o_Frame_Data,
    output logic                       o_Cksum_Err,
    output logic                       o_Timeout,
    output logic                       o_Overrun
);

    localparam int unsigned           IDX_WIDTH = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(PAYLOAD_BYTES - 1);

    frame_state_e               state_q;
    logic [IDX_WIDTH-1:0]       byte_idx_q;
    logic [UART_DATA_WIDTH-1:0] cksum_q;
    logic [FRAME_WIDTH-1:0]     assemble_q;

    logic in_frame;
    logic timer_clear;
    logic timer_enable;
    logic timer_expire;

    assign in_frame     = (state_q == StPayload) || (state_q == StCheck);
    assign timer_clear  = !in_frame || i_Rx_DV;
    assign timer_enable = in_frame && !i_Rx_DV;

    uart_byte_timeout #(
        .COUNT_WIDTH (CONFIG_DATA_WIDTH),
        .LIMIT       (TIMEOUT_CLKS)
    ) u_timeout (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Clear  (timer_clear),
        .i_Enable (timer_enable),
        .o_Expire (timer_expire)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q       <= StIdle;
            byte_idx_q    <= '0;
            cksum_q       <= '0;
            assemble_q    <= '0;
            o_Frame_Data  <= '0;
            o_Frame_Valid <= 1'b0;
            o_Cksum_Err   <= 1'b0;
            o_Timeout     <= 1'b0;
            o_Overrun     <= 1'b0;
        end else begin
            o_Cksum_Err <= 1'b0;
            o_Timeout   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                        state_q    <= StPayload;
                        byte_idx_q <= '0;
                        cksum_q    <= '0;
                    end
                end
                StPayload: begin
                    if (i_Rx_DV) begin
                        assemble_q[int'(byte_idx_q)*UART_DATA_WIDTH +: UART_DATA_WIDTH] <= i_Rx_Byte;
                        cksum_q    <= cksum_q ^ i_Rx_Byte;
                        byte_idx_q <= byte_idx_q + IDX_WIDTH'(1);
                        if (byte_idx_q == LAST_IDX) begin
                            state_q <= StCheck;
                        end
                    end else if (timer_expire) begin
                        o_Timeout <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StCheck: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == cksum_q) begin
                            o_Frame_Data  <= assemble_q;
                            o_Frame_Valid <= 1'b1;
                            state_q       <= StHold;
                        end else begin
                            o_Cksum_Err <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end else if (timer_expire) begin
                        o_Timeout <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StHold: begin
                    // The receiver is never stalled; a byte landing here is lost.
                    if (i_Rx_DV) begin
                        o_Overrun <= 1'b1;
                    end
                    if (i_Frame_Ready) begin
                        o_Frame_Valid <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Self-checking bench for uart_frame_assembler: directed frame table, timing
// corner sequences and randomized byte streams against a frame-level model.
module tb_uart_frame_assembler;

    localparam int unsigned P    = 4;
    localparam int unsigned TO   = 100;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        i_Clock = 1'b0;
    logic        i_Reset;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic        o_Frame_Valid;
    logic        i_Frame_Ready;
    logic [31:0] o_Frame_Data;
    logic        o_Cksum_Err;
    logic        o_Timeout;
    logic        o_Overrun;

    int n_checks = 0;
    int n_errors = 0;

    uart_frame_assembler #(
        .UART_DATA_WIDTH   (8),
        .CONFIG_DATA_WIDTH (32),
        .PAYLOAD_BYTES     (P),
        .SYNC_BYTE         (SYNC),
        .TIMEOUT_CLKS      (32'd100)
    ) dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .i_Rx_DV       (i_Rx_DV),
        .i_Rx_Byte     (i_Rx_Byte),
        .o_Frame_Valid (o_Frame_Valid),
        .i_Frame_Ready (i_Frame_Ready),
        .o_Frame_Data  (o_Frame_Data),
        .o_Cksum_Err   (o_Cksum_Err),
        .o_Timeout     (o_Timeout),
        .o_Overrun     (o_Overrun)
    );

    always #5 i_Clock = ~i_Clock;

    // Frame-level reference: bytes collected since the sync marker, gap in clocks.
    logic [7:0]  m_bytes[$];
    bit          m_in_frame = 0;
    int          m_gap      = 0;
    bit          m_valid = 0, m_err = 0, m_to = 0, m_ov = 0;
    logic [31:0] m_data  = '0;

    function automatic logic [7:0] xor_payload(input logic [7:0] q[$]);
        logic [7:0] x = '0;
        for (int k = 0; k < int'(P); k++) x ^= q[k];
        return x;
    endfunction

    task automatic model_step(input bit rst, input bit dv, input logic [7:0] b, input bit rdy);
        m_err = 0;
        m_to  = 0;
        if (rst) begin
            m_in_frame = 0; m_valid = 0; m_ov = 0; m_data = '0; m_gap = 0;
            m_bytes.delete();
        end else if (m_valid) begin
            if (dv) m_ov = 1;
            if (rdy) m_valid = 0;
        end else if (!m_in_frame) begin
            if (dv && b == SYNC) begin
                m_in_frame = 1; m_gap = 0;
                m_bytes.delete();
            end
        end else if (dv) begin
            m_bytes.push_back(b);
            m_gap = 0;
            if (m_bytes.size() == int'(P) + 1) begin
                m_in_frame = 0;
                if (xor_payload(m_bytes) == b) begin
                    m_valid = 1;
                    for (int k = 0; k < int'(P); k++) m_data[8*k +: 8] = m_bytes[k];
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            m_gap++;
            if (m_gap == int'(TO)) begin
                m_to = 1;
                m_in_frame = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, step the model at the edge, compare all outputs after it.
    task automatic cycle(input bit rst, input bit dv, input logic [7:0] b, input bit rdy);
        i_Reset = rst; i_Rx_DV = dv; i_Rx_Byte = b; i_Frame_Ready = rdy;
        @(posedge i_Clock);
        model_step(rst, dv, b, rdy);
        #1;
        check("cycle {valid,err,timeout,overrun,data}",
              {o_Frame_Valid, o_Cksum_Err, o_Timeout, o_Overrun, o_Frame_Data},
              {m_valid, m_err, m_to, m_ov, m_data});
    endtask

    typedef struct {
        int          n;
        logic [7:0]  b [10];
        logic [31:0] exp_data;
        bit          exp_valid;
        bit          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic apply_vec(input vec_t v, input string name);
        for (int i = 0; i < v.n; i++) cycle(0, 1, v.b[i], 1);
        check({name, " valid"}, 64'(o_Frame_Valid), 64'(v.exp_valid));
        check({name, " flags"}, 64'({o_Cksum_Err, o_Timeout}), 64'({v.exp_err, 1'b0}));
        if (v.exp_valid) check({name, " data"}, 64'(o_Frame_Data), 64'(v.exp_data));
        cycle(0, 0, 8'h00, 1);
        check({name, " valid_one_cycle"}, 64'(o_Frame_Valid), 64'd0);
        check({name, " err_one_cycle"}, 64'(o_Cksum_Err), 64'd0);
    endtask

    initial begin
        vecs[0] = '{6, '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00},
                    32'h44332211, 1, 0};
        vecs[1] = '{6, '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00},
                    32'h0, 0, 1};
        vecs[2] = '{6, '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00},
                    32'h04030201, 1, 0};
        vecs[3] = '{9, '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 8'h00},
                    32'h40302010, 1, 0};
        vecs[4] = '{6, '{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    32'hDDCCBBAA, 1, 0};

        i_Reset = 1; i_Rx_DV = 0; i_Rx_Byte = '0; i_Frame_Ready = 1;
        cycle(1, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 1);
        check("reset_state", 64'({o_Frame_Valid, o_Cksum_Err, o_Timeout, o_Overrun, o_Frame_Data}),
              64'd0);

        apply_vec(vecs[0], "good_frame");
        apply_vec(vecs[1], "bad_cksum");
        apply_vec(vecs[2], "good_after_bad");
        apply_vec(vecs[3], "garbage_then_frame");

        // Inter-byte timeout: pulse on the 100th idle clock only.
        cycle(0, 1, 8'hA5, 1); cycle(0, 1, 8'h11, 1); cycle(0, 1, 8'h22, 1);
        repeat (99) cycle(0, 0, 8'h00, 1);
        check("timeout_not_early", 64'(o_Timeout), 64'd0);
        cycle(0, 0, 8'h00, 1);
        check("timeout_pulse", 64'(o_Timeout), 64'd1);
        cycle(0, 0, 8'h00, 1);
        check("timeout_single", 64'(o_Timeout), 64'd0);
        apply_vec(vecs[2], "frame_after_timeout");

        // Byte on the limit cycle wins over the timeout.
        cycle(0, 1, 8'hA5, 1); cycle(0, 1, 8'h11, 1); cycle(0, 1, 8'h22, 1);
        repeat (99) cycle(0, 0, 8'h00, 1);
        cycle(0, 1, 8'h33, 1);
        check("limit_byte_no_timeout", 64'(o_Timeout), 64'd0);
        cycle(0, 1, 8'h44, 1);
        cycle(0, 1, 8'h44, 1);
        check("limit_frame_valid", 64'({o_Frame_Valid, o_Frame_Data}), 64'({1'b1, 32'h44332211}));
        cycle(0, 0, 8'h00, 1);

        // Hold with back-pressure, byte during hold sets sticky overrun.
        cycle(0, 1, 8'hA5, 0);
        cycle(0, 1, 8'h01, 0); cycle(0, 1, 8'h02, 0); cycle(0, 1, 8'h03, 0); cycle(0, 1, 8'h04, 0);
        cycle(0, 1, 8'h04, 0);
        repeat (3) cycle(0, 0, 8'h00, 0);
        check("hold_valid_data", 64'({o_Frame_Valid, o_Frame_Data}), 64'({1'b1, 32'h04030201}));
        cycle(0, 1, 8'hA5, 0);
        check("hold_overrun", 64'({o_Overrun, o_Frame_Valid, o_Frame_Data}),
              64'({2'b11, 32'h04030201}));
        cycle(0, 0, 8'h00, 1);
        check("transfer_drops_valid", 64'({o_Frame_Valid, o_Overrun}), 64'({1'b0, 1'b1}));
        cycle(0, 0, 8'h00, 1);
        check("overrun_sticky", 64'(o_Overrun), 64'd1);

        // Reset mid-frame clears everything, including overrun.
        cycle(0, 1, 8'hA5, 1); cycle(0, 1, 8'h11, 1);
        cycle(1, 0, 8'h00, 1);
        check("reset_mid_frame", 64'({o_Frame_Valid, o_Cksum_Err, o_Timeout, o_Overrun,
                                      o_Frame_Data}), 64'd0);
        apply_vec(vecs[4], "zero_cksum_frame");

        // Randomized streams: noise, good/bad frames, jittered gaps, random ready.
        for (int f = 0; f < 60; f++) begin
            int          kind = int'($urandom_range(0, 9));
            logic [7:0]  pay [4];
            logic [7:0]  cks = '0;
            repeat ($urandom_range(0, 2)) cycle(0, 1, 8'($urandom), ($urandom_range(0, 3) != 0));
            cycle(0, 1, SYNC, ($urandom_range(0, 3) != 0));
            for (int k = 0; k < 4; k++) begin
                pay[k] = 8'($urandom);
                cks ^= pay[k];
            end
            if (kind >= 7) cks ^= 8'($urandom_range(1, 255));
            for (int k = 0; k < 5; k++) begin
                int gap = (kind == 9 && k == 2) ? int'($urandom_range(95, 105))
                                                : int'($urandom_range(0, 2));
                repeat (gap) cycle(0, 0, 8'($urandom), ($urandom_range(0, 3) != 0));
                cycle(0, 1, (k < 4) ? pay[k] : cks, ($urandom_range(0, 3) != 0));
            end
            repeat ($urandom_range(0, 4)) cycle(0, 0, 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
